// File: rtl/reg_file_sb.sv
// Parametrised register file with two combinational read ports, one write port,
// optional write-to-read bypass, optional hardwired zero entry and a pending scoreboard.
module reg_file_sb #(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 4,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clearReq,
  input  logic              writeEnable,
  input  logic [ADDR_W-1:0] writeAddress,
  input  logic [DATA_W-1:0] writeData,
  input  logic              reserveEnable,
  input  logic [ADDR_W-1:0] reserveAddress,
  input  logic [ADDR_W-1:0] readAddress1,
  input  logic [ADDR_W-1:0] readAddress2,
  output logic [DATA_W-1:0] readData1,
  output logic [DATA_W-1:0] readData2,
  output logic              pending1,
  output logic              pending2,
  output logic              ready,
  output logic              clearing
);
  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic {CLEAR = 1'b0, READY = 1'b1} state_e;

  state_e            state;
  logic [ADDR_W-1:0] cnt;
  logic [DEPTH-1:0]  pend;
  logic [DATA_W-1:0] mem [DEPTH];

  logic              active;
  logic              wr_zero, rsv_zero, rd1_zero, rd2_zero;
  logic              wr_ok, rsv_ok;
  logic              hit1, hit2;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_wa;
  logic [DATA_W-1:0] mem_wd;

  // Handshake: ready is a pure status flag with no backpressure. A write or
  // reserve takes effect only at an edge where ready=1 and clearReq=0;
  // strobes presented at any other edge are silently dropped.
  assign active   = (state == READY) && !reset;
  assign ready    = active;
  assign clearing = (state == CLEAR);

  assign wr_zero  = (ZERO_REG != 0) && (writeAddress == '0);
  assign rsv_zero = (ZERO_REG != 0) && (reserveAddress == '0);
  assign rd1_zero = (ZERO_REG != 0) && (readAddress1 == '0);
  assign rd2_zero = (ZERO_REG != 0) && (readAddress2 == '0);

  assign wr_ok  = active && !clearReq && writeEnable && !wr_zero;
  assign rsv_ok = active && !clearReq && reserveEnable && !rsv_zero;

  // The sweep and the write port share the single memory write path.
  assign mem_we = (!reset && (state == CLEAR)) || wr_ok;
  assign mem_wa = (state == CLEAR) ? cnt : writeAddress;
  assign mem_wd = (state == CLEAR) ? '0 : writeData;

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_wa] <= mem_wd;
  end

  assign hit1 = (BYPASS != 0) && wr_ok && (writeAddress == readAddress1);
  assign hit2 = (BYPASS != 0) && wr_ok && (writeAddress == readAddress2);

  assign readData1 = (!active || rd1_zero) ? '0 : (hit1 ? writeData : mem[readAddress1]);
  assign readData2 = (!active || rd2_zero) ? '0 : (hit2 ? writeData : mem[readAddress2]);
  assign pending1  = active && !rd1_zero && pend[readAddress1];
  assign pending2  = active && !rd2_zero && pend[readAddress2];

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= CLEAR;
      cnt   <= '0;
      pend  <= '0;
    end else begin
      case (state)
        CLEAR: begin
          cnt  <= cnt + ADDR_W'(1);
          pend <= '0;
          if (cnt == ADDR_W'(DEPTH - 1)) state <= READY;
        end
        READY: begin
          if (clearReq) begin
            state <= CLEAR;
            cnt   <= '0;
            pend  <= '0;
          end else begin
            if (wr_ok)  pend[writeAddress]   <= 1'b0;
            // Reserve is applied last so it wins over a same-address write.
            if (rsv_ok) pend[reserveAddress] <= 1'b1;
          end
        end
        default: state <= CLEAR;
      endcase
    end
  end
endmodule

// File: tb/tb_reg_file_sb.sv
// Directed bench for reg_file_sb: dut_a uses defaults (bypass on), dut_b has
// bypass off and a hardwired zero entry; both share the same stimulus.
module tb_reg_file_sb;
  localparam int DW = 8;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          reset, clearReq, writeEnable, reserveEnable;
  logic [AW-1:0] writeAddress, reserveAddress, readAddress1, readAddress2;
  logic [DW-1:0] writeData;

  logic [DW-1:0] a_rd1, a_rd2, b_rd1, b_rd2;
  logic          a_p1, a_p2, a_ready, a_clearing;
  logic          b_p1, b_p2, b_ready, b_clearing;

  typedef struct packed {
    logic          rdy;
    logic [DW-1:0] r1a;
    logic          p1a;
    logic [DW-1:0] r2a;
    logic          p2a;
    logic [DW-1:0] r1b;
    logic          p1b;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  int    checks = 0;
  int    errors = 0;

  always #5 clk = ~clk;

  reg_file_sb #(.DATA_W(DW), .ADDR_W(AW), .BYPASS(1), .ZERO_REG(0)) dut_a (
    .clk(clk), .reset(reset), .clearReq(clearReq),
    .writeEnable(writeEnable), .writeAddress(writeAddress), .writeData(writeData),
    .reserveEnable(reserveEnable), .reserveAddress(reserveAddress),
    .readAddress1(readAddress1), .readAddress2(readAddress2),
    .readData1(a_rd1), .readData2(a_rd2), .pending1(a_p1), .pending2(a_p2),
    .ready(a_ready), .clearing(a_clearing)
  );

  reg_file_sb #(.DATA_W(DW), .ADDR_W(AW), .BYPASS(0), .ZERO_REG(1)) dut_b (
    .clk(clk), .reset(reset), .clearReq(clearReq),
    .writeEnable(writeEnable), .writeAddress(writeAddress), .writeData(writeData),
    .reserveEnable(reserveEnable), .reserveAddress(reserveAddress),
    .readAddress1(readAddress1), .readAddress2(readAddress2),
    .readData1(b_rd1), .readData2(b_rd2), .pending1(b_p1), .pending2(b_p2),
    .ready(b_ready), .clearing(b_clearing)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic we, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                       input logic re, input logic [AW-1:0] ra,
                       input logic [AW-1:0] r1, input logic [AW-1:0] r2, input logic clr);
    writeEnable    = we;
    writeAddress   = wa;
    writeData      = wd;
    reserveEnable  = re;
    reserveAddress = ra;
    readAddress1   = r1;
    readAddress2   = r2;
    clearReq       = clr;
  endtask

  task automatic expect_out(input string nm, input logic rdy,
                            input logic [DW-1:0] r1a, input logic p1a,
                            input logic [DW-1:0] r2a, input logic p2a,
                            input logic [DW-1:0] r1b, input logic p1b);
    exp_t e;
    e.rdy = rdy; e.r1a = r1a; e.p1a = p1a; e.r2a = r2a; e.p2a = p2a; e.r1b = r1b; e.p1b = p1b;
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  task automatic expect_idle(input string nm);
    expect_out(nm, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic check(input string nm, input string fld, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s.%s actual=%h expected=%h", nm, fld, act, exp);
    end
  endtask

  // Monitor: outputs are combinational, so each cycle's expectation is
  // compared on the falling edge of the cycle in which it was queued.
  initial begin
    exp_t  e;
    string n;
    forever begin
      @(negedge clk);
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n = name_q.pop_front();
        check(n, "ready_a", {7'd0, a_ready}, {7'd0, e.rdy});
        check(n, "ready_b", {7'd0, b_ready}, {7'd0, e.rdy});
        check(n, "rd1_a",   a_rd1,           e.r1a);
        check(n, "pend1_a", {7'd0, a_p1},    {7'd0, e.p1a});
        check(n, "rd2_a",   a_rd2,           e.r2a);
        check(n, "pend2_a", {7'd0, a_p2},    {7'd0, e.p2a});
        check(n, "rd1_b",   b_rd1,           e.r1b);
        check(n, "pend1_b", {7'd0, b_p1},    {7'd0, e.p1b});
      end
    end
  end

  initial begin
    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0);

    tick(); expect_idle("rst0");
    tick(); expect_idle("rst1");
    tick(); reset = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (i > 0) tick();
      expect_idle($sformatf("sweep_init%0d", i));
    end
    for (int i = 0; i < 16; i++) begin
      tick();
      drive(0, 0, 0, 0, 0, AW'(i), AW'(15 - i), 0);
      expect_out($sformatf("zero_rd%0d", i), 1, 8'h00, 0, 8'h00, 0, 8'h00, 0);
    end

    tick(); drive(1, 5, 8'hA7, 0, 0, 5, 5, 0); expect_out("wr5_byp",   1, 8'hA7, 0, 8'hA7, 0, 8'h00, 0);
    tick(); drive(0, 0, 0, 0, 0, 5, 5, 0);     expect_out("rd5",       1, 8'hA7, 0, 8'hA7, 0, 8'hA7, 0);
    tick(); drive(0, 0, 0, 1, 3, 3, 5, 0);     expect_out("rsv3",      1, 8'h00, 0, 8'hA7, 0, 8'h00, 0);
    tick(); drive(0, 0, 0, 0, 0, 3, 3, 0);     expect_out("pend3",     1, 8'h00, 1, 8'h00, 1, 8'h00, 1);
    tick(); drive(1, 3, 8'h3C, 0, 0, 3, 3, 0); expect_out("wr3",       1, 8'h3C, 1, 8'h3C, 1, 8'h00, 1);
    tick(); drive(0, 0, 0, 0, 0, 3, 5, 0);     expect_out("wr3_after", 1, 8'h3C, 0, 8'hA7, 0, 8'h3C, 0);
    tick(); drive(1, 3, 8'h4D, 1, 3, 3, 3, 0); expect_out("wr_rsv3",   1, 8'h4D, 0, 8'h4D, 0, 8'h3C, 0);
    tick(); drive(0, 0, 0, 0, 0, 3, 3, 0);     expect_out("rsv_wins",  1, 8'h4D, 1, 8'h4D, 1, 8'h4D, 1);
    tick(); drive(1, 0, 8'hFF, 1, 0, 0, 0, 0); expect_out("wr0",       1, 8'hFF, 0, 8'hFF, 0, 8'h00, 0);
    tick(); drive(0, 0, 0, 0, 0, 0, 0, 0);     expect_out("rd0",       1, 8'hFF, 1, 8'hFF, 1, 8'h00, 0);
    tick(); drive(1, 1, 8'h5E, 0, 0, 1, 0, 0); expect_out("wr1",       1, 8'h5E, 0, 8'hFF, 1, 8'h00, 0);
    tick(); drive(0, 0, 0, 1, 1, 1, 1, 0);     expect_out("rsv1",      1, 8'h5E, 0, 8'h5E, 0, 8'h5E, 0);
    tick(); drive(0, 0, 0, 0, 0, 1, 1, 0);     expect_out("pend1",     1, 8'h5E, 1, 8'h5E, 1, 8'h5E, 1);
    tick(); drive(1, 2, 8'h11, 0, 0, 2, 3, 0); expect_out("wr2",       1, 8'h11, 0, 8'h4D, 1, 8'h00, 0);
    tick(); drive(1, 9, 8'h99, 0, 0, 9, 2, 0); expect_out("wr9",       1, 8'h99, 0, 8'h11, 0, 8'h00, 0);
    tick(); drive(0, 0, 0, 1, 4, 9, 4, 0);     expect_out("rsv4",      1, 8'h99, 0, 8'h00, 0, 8'h99, 0);
    tick(); drive(0, 0, 0, 0, 0, 4, 9, 0);     expect_out("pend4",     1, 8'h00, 1, 8'h99, 0, 8'h00, 1);
    tick(); drive(0, 0, 0, 0, 0, 4, 2, 1);     expect_out("clr_req",   1, 8'h00, 1, 8'h11, 0, 8'h00, 1);

    for (int j = 0; j < 16; j++) begin
      tick();
      if (j == 5)       drive(0, 0, 0, 0, 0, 2, 9, 1);
      else if (j == 10) drive(1, 2, 8'h33, 1, 6, 2, 6, 0);
      else              drive(0, 0, 0, 0, 0, 2, 9, 0);
      expect_idle($sformatf("clr_sweep%0d", j));
    end
    tick(); drive(0, 0, 0, 0, 0, 2, 9, 0); expect_out("post_clr_2_9", 1, 8'h00, 0, 8'h00, 0, 8'h00, 0);
    tick(); drive(0, 0, 0, 0, 0, 4, 6, 0); expect_out("post_clr_4_6", 1, 8'h00, 0, 8'h00, 0, 8'h00, 0);
    tick(); drive(0, 0, 0, 0, 0, 3, 1, 0); expect_out("post_clr_3_1", 1, 8'h00, 0, 8'h00, 0, 8'h00, 0);

    tick(); drive(1, 15, 8'hAB, 0, 0, 15, 15, 0); expect_out("wr15",     1, 8'hAB, 0, 8'hAB, 0, 8'h00, 0);
    tick(); drive(0, 0, 0, 0, 0, 15, 15, 1);      expect_out("clr_req2", 1, 8'hAB, 0, 8'hAB, 0, 8'hAB, 0);
    for (int j = 0; j < 7; j++) begin
      tick(); drive(0, 0, 0, 0, 0, 15, 14, 0);
      expect_idle($sformatf("sweep2_%0d", j));
    end
    tick(); reset = 1'b1; drive(1, 15, 8'hEE, 0, 0, 15, 14, 0); expect_idle("mid_reset");
    tick(); reset = 1'b0;
    for (int j = 0; j < 16; j++) begin
      if (j > 0) tick();
      if (j == 0)       drive(1, 15, 8'hEE, 0, 0, 15, 14, 0);
      else if (j == 15) drive(1, 14, 8'hEE, 0, 0, 15, 14, 0);
      else              drive(0, 0, 0, 0, 0, 15, 14, 0);
      expect_idle($sformatf("restart%0d", j));
    end
    tick(); drive(0, 0, 0, 0, 0, 15, 14, 0); expect_out("post_restart", 1, 8'h00, 0, 8'h00, 0, 8'h00, 0);

    tick();
    tick();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain actual=%0d pending expectations required=0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
